ssd1306_cmd_ctrl: RTL and testbench

//  Command/data sequencer for the emulated SSD1306 OLED, on the AVR clock domain.

---
 rtl/ssd1306_pkg.sv | 18 +
 rtl/ssd1306_cmd_ctrl_if.sv | 21 ++
 rtl/ssd1306_addr_gen.sv | 66 ++++++
 rtl/ssd1306_cmd_ctrl.sv | 90 +++++++++
 tb/tb_ssd1306_cmd_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: opcodes, state/mode enums and decode helper shared by the SSD1306 command sequencer
package ssd1306_pkg;
   localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
   localparam logic [7:0] OP_DISP_ON   = 8'hAF;
   localparam logic [7:0] OP_NORMAL    = 8'hA6;
   localparam logic [7:0] OP_INVERT    = 8'hA7;
   localparam logic [7:0] OP_CONTRAST  = 8'h81;
   localparam logic [7:0] OP_ADDR_MODE = 8'h20;
   localparam logic [7:0] OP_COL_ADDR  = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
   localparam logic [7:0] CONTRAST_RST = 8'h7F;
   typedef enum logic [1:0] {HORIZ = 2'b00, VERT = 2'b01, PAGE = 2'b10} addr_mode_t;
   typedef enum logic [1:0] {IDLE, ARG1, ARG2} cmd_state_t;
   // Opcodes that are followed by at least one argument byte
   function automatic logic has_arg(input logic [7:0] op);
      return op inside {8'h81, 8'h20, 8'h21, 8'h22, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
   endfunction
endpackage

// File: rtl/ssd1306_cmd_ctrl_if.sv
// ssd1306_cmd_ctrl_if: SPI byte input plus VRAM write and display-config outputs
//   byte_valid/byte_data/byte_dc : byte strobe, payload, D/C tag (master -> slave)
//   vram_we/vram_addr/vram_wdata : VRAM byte write (slave -> master)
//   display_on/invert/contrast   : panel config (slave -> master)
//   cmd_busy                     : awaiting command arguments (slave -> master)
interface ssd1306_cmd_ctrl_if #(parameter int ADDR_W = 10);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_dc;
   logic              vram_we;
   logic [ADDR_W-1:0] vram_addr;
   logic [7:0]        vram_wdata;
   logic              display_on;
   logic              invert;
   logic [7:0]        contrast;
   logic              cmd_busy;
   modport master (output byte_valid, byte_data, byte_dc,
                   input vram_we, vram_addr, vram_wdata, display_on, invert, contrast, cmd_busy);
   modport slave  (input byte_valid, byte_data, byte_dc,
                   output vram_we, vram_addr, vram_wdata, display_on, invert, contrast, cmd_busy);
endinterface

// File: rtl/ssd1306_addr_gen.sv
// ssd1306_addr_gen: column/page pointers and address windows with SSD1306 auto-increment
//   clk_avr_16, oled_reset : clock, async active-low reset
//   i_mode                 : addressing mode
//   i_ld_col_win/page_win  : load window from i_win_s/i_win_e and move pointer to start
//   i_ld_col/i_ld_page     : direct pointer load from i_col_val/i_page_val
//   i_adv                  : advance after a data write
//   o_col/o_page           : current pointers
module ssd1306_addr_gen
   import ssd1306_pkg::*;
#(
   parameter int COLS  = 128,
   parameter int PAGES = 8,
   parameter int CW    = $clog2(COLS),
   parameter int PW    = $clog2(PAGES)
) (
   input  logic          clk_avr_16,
   input  logic          oled_reset,
   input  addr_mode_t    i_mode,
   input  logic          i_ld_col_win,
   input  logic          i_ld_page_win,
   input  logic [7:0]    i_win_s,
   input  logic [7:0]    i_win_e,
   input  logic          i_ld_col,
   input  logic [CW-1:0] i_col_val,
   input  logic          i_ld_page,
   input  logic [PW-1:0] i_page_val,
   input  logic          i_adv,
   output logic [CW-1:0] o_col,
   output logic [PW-1:0] o_page
);
   logic [CW-1:0] r_col, r_col_s, r_col_e, w_col_wrap;
   logic [PW-1:0] r_page, r_page_s, r_page_e, w_page_wrap;
   logic          w_col_step, w_page_step;
   // p+1 wraps naturally at the power-of-two size, so start>end windows pass through 0
   assign w_col_wrap  = (r_col == r_col_e) ? r_col_s : r_col + 1'b1;
   assign w_page_wrap = (r_page == r_page_e) ? r_page_s : r_page + 1'b1;
   assign w_col_step  = (i_mode != VERT) || (r_page == r_page_e);
   assign w_page_step = (i_mode == VERT) || (i_mode == HORIZ && r_col == r_col_e);
   assign o_col  = r_col;
   assign o_page = r_page;
   always_ff @(posedge clk_avr_16 or negedge oled_reset) begin
      if (!oled_reset) begin
         r_col    <= '0;
         r_col_s  <= '0;
         r_col_e  <= CW'(COLS - 1);
         r_page   <= '0;
         r_page_s <= '0;
         r_page_e <= PW'(PAGES - 1);
      end else begin
         if (i_ld_col_win) begin
            r_col_s <= i_win_s[CW-1:0];
            r_col_e <= i_win_e[CW-1:0];
            r_col   <= i_win_s[CW-1:0];
         end
         if (i_ld_page_win) begin
            r_page_s <= i_win_s[PW-1:0];
            r_page_e <= i_win_e[PW-1:0];
            r_page   <= i_win_s[PW-1:0];
         end
         if (i_ld_col) r_col <= i_col_val;
         if (i_ld_page) r_page <= i_page_val;
         if (i_adv && w_col_step) r_col <= w_col_wrap;
         if (i_adv && w_page_step) r_page <= w_page_wrap;
      end
   end
endmodule

// File: rtl/ssd1306_cmd_ctrl.sv
// ssd1306_cmd_ctrl: decodes D/C-tagged SPI bytes into SSD1306 config and VRAM writes
//   clk_avr_16 : AVR 16 MHz clock
//   oled_reset : async active-low reset
//   bus        : slave side of ssd1306_cmd_ctrl_if (byte input, VRAM write, config outputs)
module ssd1306_cmd_ctrl
   import ssd1306_pkg::*;
#(
   parameter int COLS   = 128,
   parameter int PAGES  = 8,
   parameter int ADDR_W = 10
) (
   input logic                 clk_avr_16,
   input logic                 oled_reset,
   ssd1306_cmd_ctrl_if.slave   bus
);
   localparam int CW = $clog2(COLS);
   localparam int PW = $clog2(PAGES);
   cmd_state_t    r_state, w_state_nxt;
   addr_mode_t    r_mode;
   logic [7:0]    r_op, w_op_nxt, r_arg, w_b;
   logic [CW-1:0] w_col;
   logic [PW-1:0] w_page;
   logic          w_data, w_cmd_idle, w_arg1, w_arg2;
   assign w_b        = bus.byte_data;
   assign w_data     = bus.byte_valid & bus.byte_dc;
   assign w_cmd_idle = bus.byte_valid & ~bus.byte_dc & (r_state == IDLE);
   assign w_arg1     = bus.byte_valid & ~bus.byte_dc & (r_state == ARG1);
   assign w_arg2     = bus.byte_valid & ~bus.byte_dc & (r_state == ARG2);
   assign bus.cmd_busy = (r_state != IDLE);
   always_ff @(posedge clk_avr_16 or negedge oled_reset) begin
      if (!oled_reset) begin
         r_state <= IDLE;
         r_op    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
      end
   end
   // A data byte always returns to IDLE, abandoning any partially received arguments
   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      if (w_data) w_state_nxt = IDLE;
      else if (w_cmd_idle) begin
         w_op_nxt    = w_b;
         w_state_nxt = has_arg(w_b) ? ARG1 : IDLE;
      end else if (w_arg1) w_state_nxt = (r_op == OP_COL_ADDR || r_op == OP_PAGE_ADDR) ? ARG2 : IDLE;
      else if (w_arg2) w_state_nxt = IDLE;
   end
   // 00-0F replaces col[3:0], 10-17 replaces col[6:4]
   ssd1306_addr_gen #(.COLS(COLS), .PAGES(PAGES)) u_addr_gen (
      .clk_avr_16   (clk_avr_16),
      .oled_reset   (oled_reset),
      .i_mode       (r_mode),
      .i_ld_col_win (w_arg2 && r_op == OP_COL_ADDR),
      .i_ld_page_win(w_arg2 && r_op == OP_PAGE_ADDR),
      .i_win_s      (r_arg),
      .i_win_e      (w_b),
      .i_ld_col     (w_cmd_idle && w_b <= 8'h17),
      .i_col_val    (w_b[4] ? {w_b[CW-5:0], w_col[3:0]} : {w_col[CW-1:4], w_b[3:0]}),
      .i_ld_page    (w_cmd_idle && w_b[7:3] == 5'b10110),
      .i_page_val   (w_b[PW-1:0]),
      .i_adv        (w_data),
      .o_col        (w_col),
      .o_page       (w_page)
   );
   always_ff @(posedge clk_avr_16 or negedge oled_reset) begin
      if (!oled_reset) begin
         bus.vram_we    <= 1'b0;
         bus.vram_addr  <= '0;
         bus.vram_wdata <= '0;
         bus.display_on <= 1'b0;
         bus.invert     <= 1'b0;
         bus.contrast   <= CONTRAST_RST;
         r_arg          <= '0;
         r_mode         <= PAGE;
      end else begin
         bus.vram_we <= w_data;
         if (w_data) begin
            bus.vram_addr  <= ADDR_W'({w_page, w_col});
            bus.vram_wdata <= w_b;
         end
         if (w_cmd_idle && (w_b == OP_DISP_OFF || w_b == OP_DISP_ON)) bus.display_on <= w_b[0];
         if (w_cmd_idle && (w_b == OP_NORMAL || w_b == OP_INVERT)) bus.invert <= w_b[0];
         if (w_arg1 && r_op == OP_CONTRAST) bus.contrast <= w_b;
         if (w_arg1) r_arg <= w_b;
         if (w_arg1 && r_op == OP_ADDR_MODE && w_b[1:0] != 2'b11) r_mode <= addr_mode_t'(w_b[1:0]);
      end
   end
endmodule

// File: tb/tb_ssd1306_cmd_ctrl.sv
// tb_ssd1306_cmd_ctrl: directed and random byte streams checked against a command-level model
module tb_ssd1306_cmd_ctrl;
   localparam int COLS = 128, PAGES = 8;
   logic clk = 1'b0, rst_n = 1'b0;
   int   n_tests = 0, n_fail = 0;
   int   last_addr;
   always #5 clk = ~clk;
   ssd1306_cmd_ctrl_if #(.ADDR_W(10)) bus ();
   ssd1306_cmd_ctrl dut (.clk_avr_16(clk), .oled_reset(rst_n), .bus(bus));
   int m_disp, m_inv, m_con, m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_need, m_op;
   int m_args[$];
   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic void mdl_reset();
      m_disp = 0; m_inv = 0; m_con = 'h7F; m_mode = 2;
      m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
      m_col = 0; m_page = 0; m_need = 0; m_op = 0;
      m_args.delete();
   endfunction
   function automatic int nargs(input int op);
      if (op == 'h21 || op == 'h22) return 2;
      if (op inside {'h81, 'h20, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) return 1;
      return 0;
   endfunction
   function automatic int nxt(input int p, input int s, input int e, input int size);
      return (p == e) ? s : (p + 1) % size;
   endfunction
   function automatic void apply(input int op);
      case (op)
         'hAE, 'hAF: m_disp = op & 1;
         'hA6, 'hA7: m_inv = op & 1;
         'h81: m_con = m_args[0];
         'h20: if ((m_args[0] & 3) != 3) m_mode = m_args[0] & 3;
         'h21: begin m_cs = m_args[0] & 'h7F; m_ce = m_args[1] & 'h7F; m_col = m_cs; end
         'h22: begin m_ps = m_args[0] & 7; m_pe = m_args[1] & 7; m_page = m_ps; end
         default: begin
            if (op >= 'hB0 && op <= 'hB7) m_page = op - 'hB0;
            else if (op <= 'h0F) m_col = (m_col & 'h70) | op;
            else if (op <= 'h17) m_col = (m_col & 'h0F) | ((op & 7) << 4);
         end
      endcase
   endfunction
   function automatic int model(input bit dc, input int d);
      int a, nc, np;
      a = m_page * COLS + m_col;
      if (dc) begin
         m_need = 0;
         nc = nxt(m_col, m_cs, m_ce, COLS);
         np = nxt(m_page, m_ps, m_pe, PAGES);
         if (m_mode == 0) begin
            if (m_col == m_ce) m_page = np;
            m_col = nc;
         end else if (m_mode == 1) begin
            if (m_page == m_pe) m_col = nc;
            m_page = np;
         end else m_col = nc;
      end else if (m_need > 0) begin
         m_args.push_back(d);
         m_need--;
         if (m_need == 0) apply(m_op);
      end else begin
         m_op = d;
         m_args.delete();
         m_need = nargs(d);
         if (m_need == 0) apply(d);
      end
      return a;
   endfunction
   task automatic chk_cfg(input string tag);
      check({tag, "_disp"}, bus.display_on, m_disp);
      check({tag, "_inv"}, bus.invert, m_inv);
      check({tag, "_con"}, bus.contrast, m_con);
      check({tag, "_busy"}, bus.cmd_busy, m_need > 0);
   endtask
   task automatic send(input bit dc, input logic [7:0] d);
      int ea;
      bus.byte_valid = 1'b1;
      bus.byte_dc    = dc;
      bus.byte_data  = d;
      ea = model(dc, d);
      @(negedge clk);
      check("we", bus.vram_we, dc);
      if (dc) begin
         check("addr", bus.vram_addr, ea);
         check("wdata", bus.vram_wdata, d);
         last_addr = bus.vram_addr;
      end
      chk_cfg("cfg");
   endtask
   task automatic cmds(input int q[$]);
      foreach (q[i]) send(1'b0, 8'(q[i]));
   endtask
   task automatic idle(input int n);
      bus.byte_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_we", bus.vram_we, 0);
      end
   endtask
   task automatic do_reset();
      bus.byte_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_we", bus.vram_we, 0);
      check("rst_addr", bus.vram_addr, 0);
      check("rst_wdata", bus.vram_wdata, 0);
      check("rst_disp", bus.display_on, 0);
      check("rst_inv", bus.invert, 0);
      check("rst_con", bus.contrast, 'h7F);
      check("rst_busy", bus.cmd_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mdl_reset();
   endtask
   initial begin
      int e3[5] = '{'h110, 'h111, 'h190, 'h191, 'h110};
      int e4[3] = '{'h305, 'h385, 'h306};
      bus.byte_valid = 1'b0; bus.byte_dc = 1'b0; bus.byte_data = '0;
      mdl_reset();
      @(negedge clk);
      do_reset();
      idle(20);
      chk_cfg("t1");
      cmds('{'h20, 'h00, 'h21, 'h00, 'h7F, 'h22, 'h00, 'h07});
      for (int i = 0; i < 1025; i++) begin
         send(1'b1, 8'($urandom));
         check("t2_seq", last_addr, i % 1024);
      end
      idle(1);
      do_reset();
      cmds('{'h20, 'h00, 'h21, 'h10, 'h11, 'h22, 'h02, 'h03});
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 8'($urandom));
         check("t3_addr", last_addr, e3[i]);
      end
      idle(1);
      do_reset();
      cmds('{'h20, 'h01, 'h21, 'h05, 'h06, 'h22, 'h06, 'h07});
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 8'($urandom));
         check("t4_addr", last_addr, e4[i]);
      end
      idle(1);
      do_reset();
      cmds('{'h20, 'h02, 'hB3, 'h0F, 'h12});
      send(1'b1, 8'h11); check("t5_a0", last_addr, 'h1AF);
      send(1'b1, 8'h22); check("t5_a1", last_addr, 'h1B0);
      cmds('{'h0F, 'h17});
      send(1'b1, 8'h33); check("t5_a2", last_addr, 'h1FF);
      send(1'b1, 8'h44); check("t5_a3", last_addr, 'h180);
      idle(1);
      do_reset();
      send(1'b0, 8'h81);
      check("t6_busy", bus.cmd_busy, 1);
      send(1'b1, 8'hAA);
      check("t6_abort", bus.cmd_busy, 0);
      check("t6_con7f", bus.contrast, 'h7F);
      check("t6_wd", bus.vram_wdata, 'hAA);
      cmds('{'h81, 'h40});
      check("t6_con40", bus.contrast, 'h40);
      cmds('{'h21, 'h05});
      do_reset();
      send(1'b0, 8'h10);
      check("t6_nobusy", bus.cmd_busy, 0);
      send(1'b1, 8'h5A);
      check("t6_addr0", last_addr, 0);
      idle(1);
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int r = $urandom_range(0, 99);
         int ops[14] = '{'hAE, 'hAF, 'hA6, 'hA7, 'h81, 'h20, 'h21, 'h22, 'hB0, 'h00, 'h10, 'h8D, 'hA8, 'hE3};
         int op;
         if (r < 40) send(1'b1, 8'($urandom));
         else if (r < 45) idle(1);
         else if (m_need > 0 && r < 80) send(1'b0, (m_op == 'h20) ? 8'($urandom_range(0, 3)) : 8'($urandom));
         else begin
            op = ops[$urandom_range(0, 13)];
            if (op == 'hB0) op += $urandom_range(0, 7);
            else if (op == 'h00) op += $urandom_range(0, 15);
            else if (op == 'h10) op += $urandom_range(0, 7);
            send(1'b0, 8'(op));
         end
      end
      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
